mem_stage_ctrl: RTL and testbench

- Parametrised MEM-stage controller for the 5-stage MIPS pipeline; successor to the combinational MEM control decode.
- Decodes the 3-bit M control vector together with opcode [31:26].
- Drives a data-memory request/ready handshake with variable wait states and byte/half/word access with sign or zero extension.
- Stalls the pipeline while an access is outstanding, resolves BEQ/BNE to pcsrc, and aborts hung accesses via a timeout.

---
 rtl/mem_stage_ctrl_if.sv | 22 ++
 rtl/mem_stage_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ready bus between the MEM-stage controller and data memory.
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: decodes the M control vector and opcode, runs the
// data-memory handshake with wait states and timeout, extracts/extends load
// data, stalls the pipeline while busy and resolves BEQ/BNE.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [5:0]        opcode,
  input  logic [2:0]        m_ctrl,
  input  logic              zero,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [31:0]       store_data,
  mem_stage_ctrl_if.master  bus,
  output logic              stall,
  output logic              pcsrc,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              err
);

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  // Counter only needs to reach TIMEOUT-1; TIMEOUT=0 disables the abort path.
  localparam int              CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit              TO_EN   = (TIMEOUT != 0);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;

  // Pick the addressed lane and sign/zero extend it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] rdata, input logic [1:0] lo,
                                               input size_t sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = rdata[{lo, 3'b000} +: 8];
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (sz)
      SZ_BYTE: res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              req_r, req_nxt_s;
  logic              we_r, we_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [31:0]       wdata_r, wdata_nxt_s;
  logic [3:0]        be_r, be_nxt_s;
  logic [1:0]        lo_r, lo_nxt_s;
  size_t             size_r, size_nxt_s;
  logic              uns_r, uns_nxt_s;
  logic [31:0]       load_data_r, load_data_nxt_s;
  logic              load_valid_r, load_valid_nxt_s;
  logic              err_r, err_nxt_s;

  size_t             size_s;
  logic              uns_s;
  logic              is_mem_s;
  logic              illegal_s;
  logic              misalign_s;
  logic [1:0]        lo_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;
  logic              br_take_s;

  assign is_mem_s  = m_ctrl[1] | m_ctrl[2];
  assign illegal_s = m_ctrl[1] & m_ctrl[2];
  assign lo_s      = alu_result[1:0];

  // Access size and signedness; sizing opcodes count only with their matching m_ctrl bit.
  always_comb begin
    size_s = SZ_WORD;
    uns_s  = 1'b0;
    if (m_ctrl[2] & ~m_ctrl[1]) begin
      case (opcode)
        OP_SB:   size_s = SZ_BYTE;
        OP_SH:   size_s = SZ_HALF;
        default: size_s = SZ_WORD;
      endcase
    end else if (m_ctrl[1] & ~m_ctrl[2]) begin
      case (opcode)
        OP_LB:   size_s = SZ_BYTE;
        OP_LH:   size_s = SZ_HALF;
        OP_LBU:  begin size_s = SZ_BYTE; uns_s = 1'b1; end
        OP_LHU:  begin size_s = SZ_HALF; uns_s = 1'b1; end
        default: size_s = SZ_WORD;
      endcase
    end else begin
      size_s = SZ_WORD;
    end
  end

  // Alignment check, byte enables and lane-replicated store data.
  always_comb begin
    case (size_s)
      SZ_BYTE: begin
        misalign_s = 1'b0;
        be_s       = 4'b0001 << lo_s;
        wdata_s    = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        misalign_s = lo_s[0];
        be_s       = lo_s[1] ? 4'b1100 : 4'b0011;
        wdata_s    = {2{store_data[15:0]}};
      end
      default: begin
        misalign_s = (lo_s != 2'b00);
        be_s       = 4'b1111;
        wdata_s    = store_data;
      end
    endcase
  end

  // Branch condition for BEQ/BNE; any other opcode never branches.
  always_comb begin
    case (opcode)
      OP_BEQ:  br_take_s = zero;
      OP_BNE:  br_take_s = ~zero;
      default: br_take_s = 1'b0;
    endcase
  end

  // Next-state, request fields, stall and branch resolution.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    req_nxt_s        = req_r;
    we_nxt_s         = we_r;
    addr_nxt_s       = addr_r;
    wdata_nxt_s      = wdata_r;
    be_nxt_s         = be_r;
    lo_nxt_s         = lo_r;
    size_nxt_s       = size_r;
    uns_nxt_s        = uns_r;
    load_data_nxt_s  = load_data_r;
    load_valid_nxt_s = 1'b0;
    err_nxt_s        = 1'b0;
    stall            = 1'b0;
    pcsrc            = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pcsrc = in_valid & m_ctrl[0] & br_take_s;
        if (in_valid & illegal_s) begin
          err_nxt_s = 1'b1;
        end else if (in_valid & is_mem_s & misalign_s) begin
          err_nxt_s = 1'b1;
        end else if (in_valid & is_mem_s) begin
          stall       = 1'b1;
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = '0;
          req_nxt_s   = 1'b1;
          we_nxt_s    = m_ctrl[2];
          addr_nxt_s  = {alu_result[ADDR_W-1:2], 2'b00};
          wdata_nxt_s = wdata_s;
          be_nxt_s    = be_s;
          lo_nxt_s    = lo_s;
          size_nxt_s  = size_s;
          uns_nxt_s   = uns_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        stall = ~bus.mem_ready;
        if (bus.mem_ready) begin
          req_nxt_s   = 1'b0;
          state_nxt_s = ST_IDLE;
          if (!we_r) begin
            load_data_nxt_s  = extract_load(bus.mem_rdata, lo_r, size_r, uns_r);
            load_valid_nxt_s = 1'b1;
          end else begin
            load_valid_nxt_s = 1'b0;
          end
        end else if (TO_EN && (cnt_r == TO_LAST)) begin
          req_nxt_s   = 1'b0;
          err_nxt_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        req_nxt_s   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset returns everything to idle zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= 32'h0000_0000;
      be_r         <= 4'b0000;
      lo_r         <= 2'b00;
      size_r       <= SZ_WORD;
      uns_r        <= 1'b0;
      load_data_r  <= 32'h0000_0000;
      load_valid_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      req_r        <= req_nxt_s;
      we_r         <= we_nxt_s;
      addr_r       <= addr_nxt_s;
      wdata_r      <= wdata_nxt_s;
      be_r         <= be_nxt_s;
      lo_r         <= lo_nxt_s;
      size_r       <= size_nxt_s;
      uns_r        <= uns_nxt_s;
      load_data_r  <= load_data_nxt_s;
      load_valid_r <= load_valid_nxt_s;
      err_r        <= err_nxt_s;
    end
  end

  assign bus.mem_req   = req_r;
  assign bus.mem_we    = we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.mem_be    = be_r;
  assign load_data     = load_data_r;
  assign load_valid    = load_valid_r;
  assign err           = err_r;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: transaction-level reference model
// checked every cycle, plus directed scenarios with hand-computed literals.
module tb_mem_stage_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic [2:0]  m_ctrl = 3'b000;
  logic        zero = 1'b0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        stall, pcsrc, load_valid, err;
  logic [31:0] load_data;

  mem_stage_ctrl_if #(.ADDR_W(32)) bus_if ();

  mem_stage_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .m_ctrl(m_ctrl),
    .zero(zero), .alu_result(alu_result), .store_data(store_data), .bus(bus_if),
    .stall(stall), .pcsrc(pcsrc), .load_data(load_data), .load_valid(load_valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int stall_cnt = 0, req_cnt = 0, err_cnt = 0;

  // Reference model state: one outstanding access, described as a transaction.
  bit          m_busy = 1'b0;
  logic [31:0] m_addr = 32'h0;
  bit          m_write = 1'b0;
  int          m_bytes = 4;
  bit          m_uns = 1'b0;
  int          m_waited = 0;
  logic        e_req = 1'b0, e_we = 1'b0, e_lv = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, e_ld = 32'h0;
  logic [3:0]  e_be = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int size_of(input logic [5:0] op, input logic [2:0] mc);
    if (mc[1]) begin
      if (op == 6'h20 || op == 6'h24) return 1;
      if (op == 6'h21 || op == 6'h25) return 2;
      return 4;
    end
    if (op == 6'h28) return 1;
    if (op == 6'h29) return 2;
    return 4;
  endfunction

  function automatic bit would_accept();
    int sz;
    sz = size_of(opcode, m_ctrl);
    return in_valid && (m_ctrl[1] ^ m_ctrl[2]) && ((alu_result % sz) == 0);
  endfunction

  // Model update at each clock edge from the inputs the DUT sees.
  always @(posedge clk) begin
    logic [31:0] v;
    e_lv  = 1'b0;
    e_err = 1'b0;
    if (rst) begin
      m_busy = 1'b0; e_req = 1'b0; e_we = 1'b0; e_addr = 32'h0;
      e_wdata = 32'h0; e_be = 4'h0; e_ld = 32'h0;
    end else if (m_busy) begin
      if (bus_if.mem_ready) begin
        m_busy = 1'b0;
        e_req  = 1'b0;
        if (!m_write) begin
          v = bus_if.mem_rdata >> ((m_addr % 4) * 8);
          if (m_bytes == 1)      e_ld = m_uns ? (v & 32'hFF) : 32'($signed(v[7:0]));
          else if (m_bytes == 2) e_ld = m_uns ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
          else                   e_ld = v;
          e_lv = 1'b1;
        end
      end else begin
        m_waited++;
        if (TO != 0 && m_waited == TO) begin
          m_busy = 1'b0; e_req = 1'b0; e_err = 1'b1;
        end
      end
    end else if (in_valid && (m_ctrl[1] || m_ctrl[2])) begin
      if (m_ctrl[1] && m_ctrl[2]) e_err = 1'b1;
      else if (!would_accept()) e_err = 1'b1;
      else begin
        m_busy   = 1'b1;
        m_waited = 0;
        m_addr   = alu_result;
        m_write  = m_ctrl[2];
        m_bytes  = size_of(opcode, m_ctrl);
        m_uns    = m_ctrl[1] && (opcode == 6'h24 || opcode == 6'h25);
        e_req    = 1'b1;
        e_we     = m_ctrl[2];
        e_addr   = alu_result & 32'hFFFF_FFFC;
        e_be     = 4'(((1 << m_bytes) - 1) << (alu_result % 4));
        if (m_bytes == 1)      e_wdata = (store_data & 32'hFF) * 32'h0101_0101;
        else if (m_bytes == 2) e_wdata = (store_data & 32'hFFFF) * 32'h0001_0001;
        else                   e_wdata = store_data;
      end
    end
  end

  // Compare all DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'b0, stall}, {31'b0, m_busy ? !bus_if.mem_ready : would_accept()});
      chk("pcsrc", {31'b0, pcsrc}, {31'b0, !m_busy && in_valid && m_ctrl[0] &&
          ((opcode == 6'h04 && zero) || (opcode == 6'h05 && !zero))});
      chk("mem_req", {31'b0, bus_if.mem_req}, {31'b0, e_req});
      chk("mem_we", {31'b0, bus_if.mem_we}, {31'b0, e_we});
      chk("mem_addr", bus_if.mem_addr, e_addr);
      chk("mem_wdata", bus_if.mem_wdata, e_wdata);
      chk("mem_be", {28'b0, bus_if.mem_be}, {28'b0, e_be});
      chk("load_valid", {31'b0, load_valid}, {31'b0, e_lv});
      chk("load_data", load_data, e_ld);
      chk("err", {31'b0, err}, {31'b0, e_err});
      if (stall) stall_cnt++;
      if (bus_if.mem_req) req_cnt++;
      if (err) err_cnt++;
    end
  end

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  logic acc_stall, acc_pcsrc;

  // Present one instruction for one cycle, capturing the combinational outputs.
  task automatic drive_op(input logic [5:0] op, input logic [2:0] mc, input logic [31:0] addr,
                          input logic [31:0] sd, input logic z);
    in_valid = 1'b1; opcode = op; m_ctrl = mc; alu_result = addr; store_data = sd; zero = z;
    @(negedge clk);
    #1;
    acc_stall = stall;
    acc_pcsrc = pcsrc;
    settle();
    in_valid = 1'b0; opcode = 6'h00; m_ctrl = 3'b000;
  endtask

  // Memory answers in the given WAIT cycle (1-based); caller is in WAIT cycle 1.
  task automatic respond(input int delay, input logic [31:0] rd);
    for (int i = 1; i < delay; i++) settle();
    bus_if.mem_ready = 1'b1;
    bus_if.mem_rdata = rd;
    settle();
    bus_if.mem_ready = 1'b0;
    bus_if.mem_rdata = 32'h5A5A_5A5A;
  endtask

  task automatic load_case(input string name, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] exp);
    drive_op(op, 3'b010, addr, 32'h0, 1'b0);
    respond(1, rd);
    chk({name, "_lv"}, {31'b0, load_valid}, 32'd1);
    chk(name, load_data, exp);
    chk({name, "_model"}, e_ld, exp);
    settle();
  endtask

  initial begin
    bus_if.mem_ready = 1'b0;
    bus_if.mem_rdata = 32'h0;
    repeat (3) settle();
    rst = 1'b0;
    chk("rst_req", {31'b0, bus_if.mem_req}, 32'd0);
    chk("rst_load_data", load_data, 32'h0);
    chk_en = 1'b1;
    settle();

    // LW with ready in the third WAIT cycle
    stall_cnt = 0;
    drive_op(6'h23, 3'b010, 32'h100, 32'h0, 1'b0);
    chk("lw_acc_stall", {31'b0, acc_stall}, 32'd1);
    chk("lw_be", {28'b0, bus_if.mem_be}, 32'hF);
    chk("lw_req", {31'b0, bus_if.mem_req}, 32'd1);
    respond(3, 32'hDEAD_BEEF);
    chk("lw_stall_cycles", stall_cnt, 32'd3);
    chk("lw_data", load_data, 32'hDEAD_BEEF);
    settle();

    load_case("lb", 6'h20, 32'h103, 32'h8011_2233, 32'hFFFF_FF80);
    load_case("lbu", 6'h24, 32'h103, 32'h8011_2233, 32'h0000_0080);
    load_case("lh", 6'h21, 32'h102, 32'h8011_2233, 32'hFFFF_8011);
    load_case("lhu", 6'h25, 32'h100, 32'h8011_A233, 32'h0000_A233);

    // Stores
    drive_op(6'h28, 3'b100, 32'h201, 32'h0000_00AB, 1'b0);
    chk("sb_we", {31'b0, bus_if.mem_we}, 32'd1);
    chk("sb_be", {28'b0, bus_if.mem_be}, 32'h2);
    chk("sb_wdata", bus_if.mem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", bus_if.mem_addr, 32'h200);
    chk("sb_model_wdata", e_wdata, 32'hABAB_ABAB);
    respond(2, 32'h0);
    chk("sb_no_lv", {31'b0, load_valid}, 32'd0);
    drive_op(6'h29, 3'b100, 32'h202, 32'h0000_1234, 1'b0);
    chk("sh_be", {28'b0, bus_if.mem_be}, 32'hC);
    chk("sh_wdata", bus_if.mem_wdata, 32'h1234_1234);
    respond(1, 32'h0);
    settle();

    // Misaligned word load, then illegal read+write
    drive_op(6'h23, 3'b010, 32'h101, 32'h0, 1'b0);
    chk("mis_stall", {31'b0, acc_stall}, 32'd0);
    chk("mis_err", {31'b0, err}, 32'd1);
    chk("mis_req", {31'b0, bus_if.mem_req}, 32'd0);
    drive_op(6'h23, 3'b110, 32'h100, 32'h0, 1'b0);
    chk("ill_err", {31'b0, err}, 32'd1);
    chk("ill_req", {31'b0, bus_if.mem_req}, 32'd0);
    // Ready while idle must be ignored
    bus_if.mem_ready = 1'b1;
    settle();
    bus_if.mem_ready = 1'b0;
    // Unlisted opcode with MemRead is a word access
    drive_op(6'h00, 3'b010, 32'h104, 32'h0, 1'b0);
    respond(1, 32'h1357_9BDF);
    chk("unl_data", load_data, 32'h1357_9BDF);
    settle();

    // Timeout with a branch presented during WAIT
    req_cnt = 0; err_cnt = 0;
    drive_op(6'h23, 3'b010, 32'h300, 32'h0, 1'b0);
    settle();
    in_valid = 1'b1; opcode = 6'h04; m_ctrl = 3'b001; zero = 1'b1;
    @(negedge clk);
    #1;
    chk("beq_in_wait", {31'b0, pcsrc}, 32'd0);
    settle();
    in_valid = 1'b0; opcode = 6'h00; m_ctrl = 3'b000;
    repeat (5) settle();
    chk("to_req_cycles", req_cnt, 32'd4);
    chk("to_err_pulses", err_cnt, 32'd1);
    chk("to_stall", {31'b0, stall}, 32'd0);

    // Reset in the middle of WAIT
    drive_op(6'h23, 3'b010, 32'h400, 32'h0, 1'b0);
    settle();
    rst = 1'b1;
    settle();
    chk("rst_wait_req", {31'b0, bus_if.mem_req}, 32'd0);
    chk("rst_wait_addr", bus_if.mem_addr, 32'h0);
    chk("rst_wait_lv", {31'b0, load_valid}, 32'd0);
    rst = 1'b0;
    settle();

    // Branches
    drive_op(6'h04, 3'b001, 32'h0, 32'h0, 1'b1);
    chk("beq_z1", {31'b0, acc_pcsrc}, 32'd1);
    chk("beq_nostall", {31'b0, acc_stall}, 32'd0);
    drive_op(6'h05, 3'b001, 32'h0, 32'h0, 1'b1);
    chk("bne_z1", {31'b0, acc_pcsrc}, 32'd0);
    drive_op(6'h05, 3'b001, 32'h0, 32'h0, 1'b0);
    chk("bne_z0", {31'b0, acc_pcsrc}, 32'd1);
    drive_op(6'h04, 3'b000, 32'h0, 32'h0, 1'b1);
    chk("beq_nobranch", {31'b0, acc_pcsrc}, 32'd0);
    repeat (2) settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
